// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with long-result FIFO and pending-write scoreboard
//
// Purpose: sole driver of the register file write port. Each cycle it picks one write from
//   three sources: the MEM/WB result (highest priority), the head of the long-result FIFO,
//   or a long result bypassed straight from the handshake. It also tracks destinations of
//   in-flight long operations so that issue logic can stall on RAW hazards.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   pipe_wen/pipe_rd_addr/_data       MEM/WB result, never stalled
//   lng_valid/lng_ready/lng_rd_addr/_data  long-latency result handshake
//   claim_en/claim_addr               issue stage claims a long-op destination
//   rs_addr/rt_addr -> rs_busy/rt_busy     scoreboard queries (combinational)
//   write_en/rd_addr/rd_data          registered regfile write port
//   buf_count                         FIFO occupancy
module regfile_wb_arbiter #(
   parameter int RW    = 5,
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pipe_wen,
   input  logic [RW-1:0]                pipe_rd_addr,
   input  logic [W-1:0]                 pipe_rd_data,
   input  logic                         lng_valid,
   output logic                         lng_ready,
   input  logic [RW-1:0]                lng_rd_addr,
   input  logic [W-1:0]                 lng_rd_data,
   input  logic                         claim_en,
   input  logic [RW-1:0]                claim_addr,
   input  logic [RW-1:0]                rs_addr,
   input  logic [RW-1:0]                rt_addr,
   output logic                         rs_busy,
   output logic                         rt_busy,
   output logic                         write_en,
   output logic [RW-1:0]                rd_addr,
   output logic [W-1:0]                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NREG = 1 << RW;

   logic [RW-1:0] fifo_addr [DEPTH];
   logic [W-1:0]  fifo_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [NREG-1:0] busy;

   logic          pipe_sel;
   logic          fifo_ne;
   logic          accept;
   logic          pop;
   logic          bypass;
   logic          push;
   logic          sel_valid;
   logic          sel_long;
   logic [RW-1:0] sel_addr;
   logic [W-1:0]  sel_data;
   logic          wr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Ready is purely state based so the long unit never sees a combinational loop through valid.
   assign lng_ready = rst && (count < CW'(DEPTH));
   assign accept    = lng_valid && lng_ready;
   assign pipe_sel  = pipe_wen && (pipe_rd_addr != '0);
   assign fifo_ne   = (count != '0);
   assign pop       = !pipe_sel && fifo_ne;
   assign bypass    = !pipe_sel && !fifo_ne && accept;
   assign push      = accept && !bypass;
   assign buf_count = count;

   // Bit 0 of busy is never set, so r0 always reads not-busy.
   assign rs_busy = busy[rs_addr];
   assign rt_busy = busy[rt_addr];

   always_comb begin
      sel_valid = 1'b0;
      sel_long  = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      if (pipe_sel) begin
         sel_valid = 1'b1;
         sel_addr  = pipe_rd_addr;
         sel_data  = pipe_rd_data;
      end else if (fifo_ne) begin
         sel_valid = 1'b1;
         sel_long  = 1'b1;
         sel_addr  = fifo_addr[head];
         sel_data  = fifo_data[head];
      end else if (accept) begin
         sel_valid = 1'b1;
         sel_long  = 1'b1;
         sel_addr  = lng_rd_addr;
         sel_data  = lng_rd_data;
      end
   end

   // A long result to r0 still consumes its slot but produces no strobe.
   assign wr = sel_valid && (sel_addr != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[tail] <= lng_rd_addr;
         fifo_data[tail] <= lng_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_en <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         busy     <= '0;
      end else begin
         write_en <= wr;
         if (wr) begin
            rd_addr <= sel_addr;
            rd_data <= sel_data;
         end

         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);

         // Clear first, then set, so a same-cycle re-claim keeps the bit.
         if (sel_long && wr) busy[sel_addr] <= 1'b0;
         if (claim_en && (claim_addr != '0)) busy[claim_addr] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wen;
   logic [4:0]  pipe_rd_addr;
   logic [31:0] pipe_rd_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_rd_addr;
   logic [31:0] lng_rd_data;
   logic        claim_en;
   logic [4:0]  claim_addr;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        rs_busy;
   logic        rt_busy;
   logic        write_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  buf_count;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.RW(5), .W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .pipe_wen(pipe_wen), .pipe_rd_addr(pipe_rd_addr), .pipe_rd_data(pipe_rd_data),
      .lng_valid(lng_valid), .lng_ready(lng_ready),
      .lng_rd_addr(lng_rd_addr), .lng_rd_data(lng_rd_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data), .buf_count(buf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: in-order queue of long results, expected write port, pending-claim set.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   bit          mbusy [32];
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic model_reset();
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic model_write_long(input ent_t e, output int clr);
      clr = 0;
      if (e.a != 0) begin
         m_we   = 1'b1;
         m_addr = e.a;
         m_data = e.d;
         clr    = int'(e.a);
      end else begin
         m_we = 1'b0;
      end
   endtask

   task automatic model_step();
      bit   acc;
      ent_t inc;
      ent_t h;
      int   clr;
      clr = 0;
      acc = lng_valid && (mq.size() < DEPTH);
      inc.a = lng_rd_addr;
      inc.d = lng_rd_data;
      if (pipe_wen && pipe_rd_addr != 0) begin
         m_we   = 1'b1;
         m_addr = pipe_rd_addr;
         m_data = pipe_rd_data;
         if (acc) mq.push_back(inc);
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (acc) mq.push_back(inc);
         model_write_long(h, clr);
      end else if (acc) begin
         model_write_long(inc, clr);
      end else begin
         m_we = 1'b0;
      end
      if (clr != 0) mbusy[clr] = 1'b0;
      if (claim_en && claim_addr != 0) mbusy[claim_addr] = 1'b1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst === 1'b1) model_step();
         @(negedge clk);
         if (rst !== 1'b1) model_reset();
         chk("cmp_write_en", write_en, m_we);
         chk("cmp_rd_addr", rd_addr, m_addr);
         chk("cmp_rd_data", rd_data, m_data);
         chk("cmp_lng_ready", lng_ready, (rst === 1'b1) && (mq.size() < DEPTH));
         chk("cmp_buf_count", buf_count, mq.size());
         chk("cmp_rs_busy", rs_busy, mbusy[rs_addr]);
         chk("cmp_rt_busy", rt_busy, mbusy[rt_addr]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_wen     = 1'b0;
      pipe_rd_addr = '0;
      pipe_rd_data = '0;
      lng_valid    = 1'b0;
      lng_rd_addr  = '0;
      lng_rd_data  = '0;
      claim_en     = 1'b0;
      claim_addr   = '0;
   endtask

   initial begin
      logic [4:0] got_q[$];
      logic [4:0] exp_bp [9];
      int         li;
      bit         acc;

      exp_bp = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd20, 5'd21, 5'd22, 5'd23};
      rst = 1'b0;
      idle();
      rs_addr = '0;
      rt_addr = '0;

      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         pipe_wen     = 1'($urandom);
         pipe_rd_addr = 5'($urandom);
         pipe_rd_data = $urandom;
         lng_valid    = 1'($urandom);
         lng_rd_addr  = 5'($urandom);
         lng_rd_data  = $urandom;
         claim_en     = 1'($urandom);
         claim_addr   = 5'($urandom);
         rs_addr      = 5'($urandom);
         rt_addr      = 5'($urandom);
         step();
         chk("rst_write_en", write_en, 0);
         chk("rst_lng_ready", lng_ready, 0);
         chk("rst_rs_busy", rs_busy, 0);
         chk("rst_rt_busy", rt_busy, 0);
      end
      idle();
      rs_addr = '0;
      rt_addr = '0;
      rst = 1'b1;
      #1;
      chk("rel_lng_ready", lng_ready, 1);
      step();

      // Bypass.
      lng_valid = 1'b1; lng_rd_addr = 5'd5; lng_rd_data = 32'hDEADBEEF;
      step();
      idle();
      chk("byp_write_en", write_en, 1);
      chk("byp_rd_addr", rd_addr, 5);
      chk("byp_rd_data", rd_data, 32'hDEADBEEF);
      chk("byp_buf_count", buf_count, 0);
      step();

      // Conflict.
      pipe_wen = 1'b1; pipe_rd_addr = 5'd3; pipe_rd_data = 32'h11;
      lng_valid = 1'b1; lng_rd_addr = 5'd7; lng_rd_data = 32'h22;
      step();
      idle();
      chk("cfl1_write_en", write_en, 1);
      chk("cfl1_rd_addr", rd_addr, 3);
      chk("cfl1_rd_data", rd_data, 32'h11);
      chk("cfl1_buf_count", buf_count, 1);
      step();
      chk("cfl2_write_en", write_en, 1);
      chk("cfl2_rd_addr", rd_addr, 7);
      chk("cfl2_rd_data", rd_data, 32'h22);
      chk("cfl2_buf_count", buf_count, 0);
      step();

      // Backpressure: long unit holds its result until accepted.
      li = 0;
      for (int c = 0; c < 5; c++) begin
         pipe_wen = 1'b1; pipe_rd_addr = 5'(10 + c); pipe_rd_data = 32'h100 + 32'(c);
         lng_valid = 1'b1; lng_rd_addr = 5'(20 + li); lng_rd_data = 32'h200 + 32'(li);
         acc = lng_ready;
         step();
         if (acc) li++;
         if (write_en) got_q.push_back(rd_addr);
         if (c == 1) begin
            chk("bp_full_count", buf_count, 2);
            chk("bp_ready_low", lng_ready, 0);
         end
      end
      pipe_wen = 1'b0; pipe_rd_addr = '0; pipe_rd_data = '0;
      for (int c = 0; c < 12; c++) begin
         if (li < 4) begin
            lng_valid = 1'b1; lng_rd_addr = 5'(20 + li); lng_rd_data = 32'h200 + 32'(li);
         end else begin
            lng_valid = 1'b0; lng_rd_addr = '0; lng_rd_data = '0;
         end
         acc = lng_ready && lng_valid;
         step();
         if (acc) li++;
         if (write_en) got_q.push_back(rd_addr);
      end
      chk("bp_write_count", got_q.size(), 9);
      for (int i = 0; i < 9; i++)
         chk("bp_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_bp[i]));
      chk("bp_drained", buf_count, 0);
      idle();

      // Scoreboard.
      rs_addr = 5'd9; rt_addr = 5'd0;
      claim_en = 1'b1; claim_addr = 5'd9;
      step();
      idle();
      chk("sb_set", rs_busy, 1);
      lng_valid = 1'b1; lng_rd_addr = 5'd9; lng_rd_data = 32'h99;
      step();
      idle();
      chk("sb_clear", rs_busy, 0);
      chk("sb_clear_we", write_en, 1);
      chk("sb_clear_addr", rd_addr, 9);
      claim_en = 1'b1; claim_addr = 5'd9;
      step();
      idle();
      chk("sb_set2", rs_busy, 1);
      claim_en = 1'b1; claim_addr = 5'd9;
      lng_valid = 1'b1; lng_rd_addr = 5'd9; lng_rd_data = 32'h9A;
      step();
      idle();
      chk("sb_reclaim", rs_busy, 1);
      chk("sb_reclaim_data", rd_data, 32'h9A);
      claim_en = 1'b1; claim_addr = 5'd0;
      step();
      idle();
      chk("sb_r0", rt_busy, 0);
      lng_valid = 1'b1; lng_rd_addr = 5'd9; lng_rd_data = 32'h9B;
      step();
      idle();
      chk("sb_clear2", rs_busy, 0);

      // Long result to r0, then a dropped r0 pipe write that must not block.
      lng_valid = 1'b1; lng_rd_addr = 5'd0; lng_rd_data = 32'h55;
      step();
      idle();
      chk("r0_long_we", write_en, 0);
      chk("r0_long_hold", rd_addr, 9);
      pipe_wen = 1'b1; pipe_rd_addr = 5'd0; pipe_rd_data = 32'h66;
      lng_valid = 1'b1; lng_rd_addr = 5'd6; lng_rd_data = 32'h77;
      step();
      idle();
      chk("r0_pipe_we", write_en, 1);
      chk("r0_pipe_addr", rd_addr, 6);
      chk("r0_pipe_data", rd_data, 32'h77);
      step();

      // Mid-operation reset.
      rs_addr = 5'd4;
      claim_en = 1'b1; claim_addr = 5'd4;
      pipe_wen = 1'b1; pipe_rd_addr = 5'd1; pipe_rd_data = 32'hA1;
      lng_valid = 1'b1; lng_rd_addr = 5'd4; lng_rd_data = 32'hB1;
      step();
      claim_en = 1'b0; claim_addr = '0;
      pipe_rd_addr = 5'd2; pipe_rd_data = 32'hA2;
      lng_rd_data = 32'hB2;
      step();
      idle();
      chk("mr_count", buf_count, 2);
      chk("mr_busy", rs_busy, 1);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mr_no_write", write_en, 0);
      end
      chk("mr_busy_clr", rs_busy, 0);
      chk("mr_count_clr", buf_count, 0);

      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
